// File: rtl/buyruk_bellegi_pkg.sv
// rtl/buyruk_bellegi_pkg.sv - shared constants and FSM states for the instruction memory
package buyruk_bellegi_pkg;

  localparam logic [31:0] NOP_BUYRUK = 32'h0000_0013;

  typedef enum logic {
    CALIS = 1'b0,
    YUKLE = 1'b1
  } durum_t;

endpackage

// File: rtl/buyruk_bellegi_bayt_birlestirici.sv
// rtl/buyruk_bellegi_bayt_birlestirici.sv - packs little-endian load bytes into 32-bit words
module bayt_birlestirici (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        temizle_i,
  input  logic        gecerli_i,
  input  logic [7:0]  bayt_i,
  input  logic        bitir_i,
  output logic        yaz_o,
  output logic [31:0] kelime_o
);

  logic [31:0] r_tampon;
  logic [1:0]  r_sayac;
  logic [31:0] w_tampon_sonraki;
  logic [1:0]  w_sayac_sonraki;

  always_comb begin
    w_tampon_sonraki = r_tampon;
    w_sayac_sonraki  = r_sayac;
    if (gecerli_i) begin
      w_tampon_sonraki[{r_sayac, 3'b000} +: 8] = bayt_i;
      w_sayac_sonraki = r_sayac + 2'd1;
    end
  end

  // A byte arriving with bitir is folded in first; the wrapped counter hides an empty tail.
  assign yaz_o    = (gecerli_i && (r_sayac == 2'd3)) || (bitir_i && (w_sayac_sonraki != 2'd0));
  assign kelime_o = w_tampon_sonraki;

  always_ff @(posedge clk_i) begin
    if (rst_i || temizle_i) begin
      r_tampon <= '0;
      r_sayac  <= '0;
    end else if (yaz_o) begin
      r_tampon <= '0;
      r_sayac  <= '0;
    end else if (gecerli_i) begin
      r_tampon <= w_tampon_sonraki;
      r_sayac  <= w_sayac_sonraki;
    end
  end

endmodule

// File: rtl/buyruk_bellegi.sv
// rtl/buyruk_bellegi.sv - instruction memory with combinational fetch and byte-serial program load
module buyruk_bellegi
  import buyruk_bellegi_pkg::*;
#(
  parameter int          BELLEK_DERINLIK = 1024,
  parameter logic [31:0] BASLANGIC_ADRES = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] buyruk_adres_i,
  output logic [31:0] buyruk_o,
  input  logic        yukle_baslat_i,
  input  logic        yukle_gecerli_i,
  input  logic [7:0]  yukle_bayt_i,
  output logic        yukle_hazir_o,
  input  logic        yukle_bitir_i,
  output logic        calisiyor_o,
  output logic        adres_hata_o,
  output logic        tasma_o
);

  localparam int          AW            = $clog2(BELLEK_DERINLIK);
  localparam logic [32:0] KAPASITE_BAYT = 33'(BELLEK_DERINLIK) << 2;
  localparam logic [AW:0] DOLU_SAYI     = (AW + 1)'(BELLEK_DERINLIK);
  localparam logic [AW:0] BIR           = (AW + 1)'(1);

  logic [31:0] r_bellek [BELLEK_DERINLIK];
  durum_t      r_durum;
  logic [AW:0] r_kelime_sayac;
  logic        r_tasma;

  logic        w_yukle;
  logic        w_dolu;
  logic        w_bayt_al;
  logic        w_bitir;
  logic        w_yaz;
  logic [31:0] w_kelime;
  logic [31:0] w_ofset;

  assign w_yukle   = (r_durum == YUKLE);
  assign w_dolu    = (r_kelime_sayac == DOLU_SAYI);
  // A restart wins over any byte or finish arriving in the same cycle.
  assign w_bayt_al = w_yukle && yukle_gecerli_i && !yukle_baslat_i && !w_dolu;
  assign w_bitir   = w_yukle && yukle_bitir_i && !yukle_baslat_i;

  bayt_birlestirici u_birlestirici (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .temizle_i (yukle_baslat_i),
    .gecerli_i (w_bayt_al),
    .bayt_i    (yukle_bayt_i),
    .bitir_i   (w_bitir),
    .yaz_o     (w_yaz),
    .kelime_o  (w_kelime)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum        <= CALIS;
      r_kelime_sayac <= '0;
      r_tasma        <= 1'b0;
    end else if (yukle_baslat_i) begin
      r_durum        <= YUKLE;
      r_kelime_sayac <= '0;
      r_tasma        <= 1'b0;
    end else begin
      if (w_yaz) r_kelime_sayac <= r_kelime_sayac + BIR;
      if (w_yukle && yukle_gecerli_i && w_dolu) r_tasma <= 1'b1;
      if (w_bitir) r_durum <= CALIS;
    end
  end

  // Contents survive reset so a loaded program outlives a core reset.
  always_ff @(posedge clk_i) begin
    if (w_yaz && !rst_i) r_bellek[r_kelime_sayac[AW-1:0]] <= w_kelime;
  end

  assign w_ofset      = buyruk_adres_i - BASLANGIC_ADRES;
  assign adres_hata_o = (buyruk_adres_i[1:0] != 2'b00) ||
                        (buyruk_adres_i < BASLANGIC_ADRES) ||
                        ({1'b0, w_ofset} >= KAPASITE_BAYT);
  assign buyruk_o     = (adres_hata_o || w_yukle) ? NOP_BUYRUK : r_bellek[w_ofset[AW+1:2]];

  assign yukle_hazir_o = w_yukle;
  assign calisiyor_o   = !w_yukle;
  assign tasma_o       = r_tasma;

endmodule

// File: tb/tb_buyruk_bellegi.sv
// tb/tb_buyruk_bellegi.sv - self-checking bench for buyruk_bellegi
module tb_buyruk_bellegi;

  localparam int          D0  = 1024;
  localparam logic [31:0] B0  = 32'h0000_0000;
  localparam int          D1  = 4;
  localparam logic [31:0] B1  = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, baslat, gecerli, bitir;
  logic [7:0]  bayt;
  logic [31:0] adr0, adr1, insn0, insn1;
  logic        hazir0, hazir1, cal0, cal1, hata0, hata1, tas0, tas1;

  always #5 clk = ~clk;

  buyruk_bellegi #(.BELLEK_DERINLIK(D0), .BASLANGIC_ADRES(B0)) dut0 (
    .clk_i(clk), .rst_i(rst), .buyruk_adres_i(adr0), .buyruk_o(insn0),
    .yukle_baslat_i(baslat), .yukle_gecerli_i(gecerli), .yukle_bayt_i(bayt),
    .yukle_hazir_o(hazir0), .yukle_bitir_i(bitir), .calisiyor_o(cal0),
    .adres_hata_o(hata0), .tasma_o(tas0)
  );

  buyruk_bellegi #(.BELLEK_DERINLIK(D1), .BASLANGIC_ADRES(B1)) dut1 (
    .clk_i(clk), .rst_i(rst), .buyruk_adres_i(adr1), .buyruk_o(insn1),
    .yukle_baslat_i(baslat), .yukle_gecerli_i(gecerli), .yukle_bayt_i(bayt),
    .yukle_hazir_o(hazir1), .yukle_bitir_i(bitir), .calisiyor_o(cal1),
    .adres_hata_o(hata1), .tasma_o(tas1)
  );

  logic [31:0] m0 [D0];
  bit          v0 [D0];
  logic [31:0] m1 [D1];
  bit          v1 [D1];
  logic [7:0]  q [$];
  bit          m_yukle, m_tas0, m_tas1;
  int          total, bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int w);
    logic [31:0] x = '0;
    for (int b = 0; b < 4; b++)
      if (4 * w + b < q.size()) x[8*b +: 8] = q[4*w+b];
    return x;
  endfunction

  task automatic commit(input bit full_only);
    int nw = full_only ? q.size() / 4 : (q.size() + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      if (w < D0) begin m0[w] = pack(w); v0[w] = 1'b1; end
      if (w < D1) begin m1[w] = pack(w); v1[w] = 1'b1; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    if (m_yukle) commit(1'b1);
    q.delete(); m_yukle = 1'b0; m_tas0 = 1'b0; m_tas1 = 1'b0;
  endtask

  task automatic start();
    baslat = 1'b1; tick(); baslat = 1'b0;
    if (m_yukle) commit(1'b1);
    q.delete(); m_yukle = 1'b1; m_tas0 = 1'b0; m_tas1 = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit with_bitir);
    gecerli = 1'b1; bayt = b; bitir = with_bitir; tick();
    gecerli = 1'b0; bitir = 1'b0;
    if (m_yukle) begin
      if (q.size() >= 4 * D0) m_tas0 = 1'b1;
      if (q.size() >= 4 * D1) m_tas1 = 1'b1;
      q.push_back(b);
      if (with_bitir) begin commit(1'b0); q.delete(); m_yukle = 1'b0; end
    end
  endtask

  task automatic finish_load();
    bitir = 1'b1; tick(); bitir = 1'b0;
    if (m_yukle) begin commit(1'b0); q.delete(); m_yukle = 1'b0; end
  endtask

  function automatic bit herr(input logic [31:0] a, input logic [31:0] base, input int d);
    longint off = longint'({32'b0, a}) - longint'({32'b0, base});
    return (a[1:0] != 2'b00) || (off < 0) || (off >= 4 * d);
  endfunction

  task automatic check_status();
    chk("cal0", cal0, !m_yukle);
    chk("hazir0", hazir0, m_yukle);
    chk("tas0", tas0, m_tas0);
    chk("cal1", cal1, !m_yukle);
    chk("hazir1", hazir1, m_yukle);
    chk("tas1", tas1, m_tas1);
  endtask

  task automatic fetch(input logic [31:0] a0, input logic [31:0] a1);
    bit e0, e1;
    int i0, i1;
    adr0 = a0; adr1 = a1;
    @(negedge clk);
    e0 = herr(a0, B0, D0); e1 = herr(a1, B1, D1);
    i0 = int'((a0 - B0) >> 2); i1 = int'((a1 - B1) >> 2);
    chk("hata0", hata0, e0);
    chk("hata1", hata1, e1);
    if (e0 || m_yukle) chk("insn0_nop", insn0, NOP);
    else if (v0[i0]) chk("insn0", insn0, m0[i0]);
    if (e1 || m_yukle) chk("insn1_nop", insn1, NOP);
    else if (v1[i1]) chk("insn1", insn1, m1[i1]);
  endtask

  function automatic logic [31:0] rand_adr(input logic [31:0] base, input int d);
    case ($urandom_range(0, 3))
      0:       return base + 32'(4 * $urandom_range(0, 7) % (4 * d));
      1:       return base + 32'(4 * $urandom_range(0, d - 1) + $urandom_range(1, 3));
      2:       return base + 32'(4 * d + 4 * $urandom_range(0, 100));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; baslat = 1'b0; gecerli = 1'b0; bitir = 1'b0; bayt = '0;
    adr0 = B0; adr1 = B1;
    m_yukle = 1'b0; m_tas0 = 1'b0; m_tas1 = 1'b0;
    tick(); tick();
    do_reset();
    check_status();
    fetch(B0, B1);

    // Basic load of one word
    start();
    send(8'h13, 1'b0); send(8'h00, 1'b0); send(8'h50, 1'b0); send(8'h00, 1'b0);
    finish_load();
    check_status();
    fetch(B0, B1);
    chk("r032_word", insn0, 32'h0050_0013);

    // Address error cases
    fetch(B0 + 32'd2, B1 - 32'd4);
    chk("r033_nop", insn0, NOP);
    fetch(B0 + 32'(4 * D0), B1 + 32'(4 * D1));
    chk("r033_range", hata0, 1'b1);

    // Partial word zero padding
    start();
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0);
    send(8'hDD, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b0);
    finish_load();
    fetch(B0, B1);
    chk("r034_w0", insn0, 32'hDDCC_BBAA);
    fetch(B0 + 32'd4, B1 + 32'd4);
    chk("r034_w1", insn0, 32'h0000_2211);

    // Overflow on the four-word instance
    start();
    for (int j = 0; j < 17; j++) send(8'(3 * j + 1), 1'b0);
    finish_load();
    check_status();
    chk("r035_tasma", tas1, 1'b1);
    for (int w = 0; w < 4; w++) fetch(B0 + 32'(4 * w), B1 + 32'(4 * w));
    fetch(B0, B1);
    chk("r035_w0", insn1, 32'h0A07_0401);

    // Reset abandons a partial load
    start();
    send(8'hEE, 1'b0); send(8'hEF, 1'b0);
    check_status();
    fetch(B0, B1);
    do_reset();
    check_status();
    fetch(B0, B1);

    // Byte and finish in the same cycle
    start();
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h55, 1'b1);
    check_status();
    fetch(B0, B1);
    chk("r037_w0", insn0, 32'h5503_0201);

    // Finish and bytes ignored while running
    finish_load();
    send(8'h77, 1'b0);
    check_status();
    fetch(B0, B1);

    // Restart drops the partial word, keeps completed ones
    start();
    for (int j = 0; j < 5; j++) send(8'(8'h40 + j), 1'b0);
    baslat = 1'b1; bitir = 1'b1; tick(); baslat = 1'b0; bitir = 1'b0;
    commit(1'b1); q.delete(); m_tas0 = 1'b0; m_tas1 = 1'b0;
    check_status();
    for (int j = 0; j < 4; j++) send(8'(8'h90 + j), 1'b0);
    finish_load();
    fetch(B0, B1);
    fetch(B0 + 32'd4, B1 + 32'd4);

    // Randomized loads
    for (int it = 0; it < 25; it++) begin
      int n, mode;
      n = $urandom_range(0, 20);
      mode = $urandom_range(0, 3);
      start();
      for (int j = 0; j < n; j++) begin
        int gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) tick();
        send(8'($urandom), (mode == 1) && (j == n - 1));
      end
      case (mode)
        0: finish_load();
        1: if (m_yukle) finish_load();
        2: do_reset();
        default: begin start(); finish_load(); end
      endcase
      check_status();
      for (int k = 0; k < 6; k++) fetch(rand_adr(B0, D0), rand_adr(B1, D1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
